// File: rtl/coreaxitoahbl_cdc_rx_handshake.sv
// Receive side of the toggle-handshake CDC: captures the held source word when the
// synchronized request toggle differs from our ack toggle, buffering into a small FIFO.
module coreaxitoahbl_cdc_rx_handshake #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  reqToggleSync,
  input  logic [DATA_WIDTH-1:0] asyncData,
  output logic                  ackToggle,
  output logic                  rxValid,
  output logic [DATA_WIDTH-1:0] rxData,
  input  logic                  rxReady,
  output logic [CNT_WIDTH-1:0]  rxCount,
  output logic                  rxStall
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_WIDTH-1:0]  cntNext;
  logic                  pending;
  logic                  notFull;
  logic                  capture;
  logic                  pop;

  // A request is outstanding while the two toggles disagree; a full FIFO blocks
  // capture even if a pop frees a slot in the same cycle.
  assign pending = reqToggleSync ^ ackToggle;
  assign notFull = (rxCount < FULL_CNT);
  assign capture = pending & notFull;
  assign pop     = rxValid & rxReady;
  assign rxStall = pending & ~notFull;
  assign rxData  = mem[rdPtr];

  always_comb begin
    cntNext = rxCount;
    case ({capture, pop})
      2'b10:   cntNext = rxCount + CNT_WIDTH'(1);
      2'b01:   cntNext = rxCount - CNT_WIDTH'(1);
      default: cntNext = rxCount;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ackToggle <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      rxCount   <= '0;
      rxValid   <= 1'b0;
    end else begin
      ackToggle <= ackToggle ^ capture;
      if (capture) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)     rdPtr <= rdPtr + PTR_W'(1);
      rxCount   <= cntNext;
      rxValid   <= (cntNext != '0);
    end
  end

  // Storage is not reset; only occupancy and pointers define what is visible.
  always_ff @(posedge CLK) begin
    if (capture) mem[wrPtr] <= asyncData;
  end

endmodule

// File: tb/tb_coreaxitoahbl_cdc_rx_handshake.sv
// Directed vector table plus handshake stream sequences for the CDC receive block.
module tb_coreaxitoahbl_cdc_rx_handshake;

  logic        CLK;
  logic        RESET;
  logic        reqToggleSync;
  logic [31:0] asyncData;
  logic        ackToggle;
  logic        rxValid;
  logic [31:0] rxData;
  logic        rxReady;
  logic [1:0]  rxCount;
  logic        rxStall;

  int total = 0;
  int bad   = 0;

  coreaxitoahbl_cdc_rx_handshake #(
    .DATA_WIDTH(32), .FIFO_DEPTH(2), .CNT_WIDTH(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .reqToggleSync(reqToggleSync), .asyncData(asyncData),
    .ackToggle(ackToggle), .rxValid(rxValid), .rxData(rxData), .rxReady(rxReady),
    .rxCount(rxCount), .rxStall(rxStall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic        ready;
    logic        eAck;
    logic        eValid;
    logic [31:0] eData;
    logic [1:0]  eCount;
    logic        eStall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Source and sink model; optional 2-flop synchronizers on both toggles.
  task automatic runStream(input int nWords, input bit useSync, input string tag);
    logic srcReq, reqS1, ackS1, ackS2, prevAck, wasPop;
    logic [31:0] head, exp, w;
    logic [31:0] sb[$];
    int sent, recv, maxCnt, cyc;
    srcReq = reqToggleSync; reqS1 = srcReq;
    ackS1 = ackToggle; ackS2 = ackToggle; prevAck = ackToggle;
    sent = 0; recv = 0; maxCnt = 0; cyc = 0; wasPop = 1'b0; head = '0;
    while (recv < nWords && cyc < 60 * nWords + 200) begin
      step();
      cyc++;
      if (wasPop) begin
        if (sb.size() == 0) begin
          check({tag, " extra pop"}, 64'(head), 64'hDEAD_0000);
        end else begin
          exp = sb.pop_front();
          check({tag, " order"}, 64'(head), 64'(exp));
        end
        recv++;
      end
      if (ackToggle != prevAck)
        check({tag, " pending after capture"}, 64'(reqToggleSync ^ ackToggle), 64'd0);
      prevAck = ackToggle;
      if (int'(rxCount) > maxCnt) maxCnt = int'(rxCount);
      if (useSync) begin
        ackS2 = ackS1; ackS1 = ackToggle;
        reqToggleSync = reqS1; reqS1 = srcReq;
      end else begin
        ackS2 = ackToggle;
      end
      if (sent < nWords && ackS2 == srcReq) begin
        w = useSync ? $urandom : 32'(sent + 1);
        asyncData = w;
        sb.push_back(w);
        srcReq = ~srcReq;
        sent++;
        if (!useSync) reqToggleSync = srcReq;
      end
      rxReady = ($urandom_range(0, 99) < 55);
      wasPop = rxValid & rxReady;
      head = rxData;
    end
    rxReady = 1'b0;
    check({tag, " words received"}, 64'(recv), 64'(nWords));
    check({tag, " count bounded"}, 64'(maxCnt <= 2), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0,         2'd0, 1'b0};
    vecs[2]  = '{1'b0, 32'h11,        1'b0, 1'b0, 1'b1, 32'h11,        2'd1, 1'b0};
    vecs[3]  = '{1'b1, 32'h22,        1'b0, 1'b1, 1'b1, 32'h11,        2'd2, 1'b0};
    vecs[4]  = '{1'b0, 32'h33,        1'b0, 1'b1, 1'b1, 32'h11,        2'd2, 1'b1};
    vecs[5]  = '{1'b0, 32'h33,        1'b1, 1'b1, 1'b1, 32'h22,        2'd1, 1'b0};
    vecs[6]  = '{1'b0, 32'h33,        1'b0, 1'b0, 1'b1, 32'h22,        2'd2, 1'b0};
    vecs[7]  = '{1'b0, 32'h33,        1'b1, 1'b0, 1'b1, 32'h33,        2'd1, 1'b0};
    vecs[8]  = '{1'b0, 32'h33,        1'b1, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0};
    vecs[9]  = '{1'b1, 32'h44,        1'b0, 1'b1, 1'b1, 32'h44,        2'd1, 1'b0};
    vecs[10] = '{1'b0, 32'h55,        1'b1, 1'b0, 1'b1, 32'h55,        2'd1, 1'b0};
    vecs[11] = '{1'b0, 32'h55,        1'b1, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0};

    RESET = 1'b1; reqToggleSync = 1'b0; asyncData = '0; rxReady = 1'b0;
    step(); step();
    check("reset ack",   64'(ackToggle), 64'd0);
    check("reset valid", 64'(rxValid),   64'd0);
    check("reset count", 64'(rxCount),   64'd0);
    check("reset stall", 64'(rxStall),   64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      reqToggleSync = vecs[i].req;
      asyncData     = vecs[i].data;
      rxReady       = vecs[i].ready;
      step();
      check($sformatf("vec%0d ack", i),   64'(ackToggle), 64'(vecs[i].eAck));
      check($sformatf("vec%0d valid", i), 64'(rxValid),   64'(vecs[i].eValid));
      check($sformatf("vec%0d count", i), 64'(rxCount),   64'(vecs[i].eCount));
      check($sformatf("vec%0d stall", i), 64'(rxStall),   64'(vecs[i].eStall));
      if (vecs[i].eValid)
        check($sformatf("vec%0d data", i), 64'(rxData), 64'(vecs[i].eData));
    end

    // Reset between edges while full with a request pending.
    rxReady = 1'b0;
    reqToggleSync = 1'b1; asyncData = 32'h66; step();
    reqToggleSync = 1'b0; asyncData = 32'h77; step();
    reqToggleSync = 1'b1; asyncData = 32'h88; step();
    check("pre-reset count", 64'(rxCount), 64'd2);
    check("pre-reset stall", 64'(rxStall), 64'd1);
    #3;
    RESET = 1'b1;
    #1;
    check("async reset ack",   64'(ackToggle), 64'd0);
    check("async reset valid", 64'(rxValid),   64'd0);
    check("async reset stall", 64'(rxStall),   64'd0);
    check("async reset count", 64'(rxCount),   64'd0);
    reqToggleSync = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    step(); step();
    check("post-reset ack",   64'(ackToggle), 64'd0);
    check("post-reset count", 64'(rxCount),   64'd0);
    check("post-reset valid", 64'(rxValid),   64'd0);

    runStream(7, 1'b0, "wrap");
    runStream(100, 1'b1, "sync");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coreaxitoahbl_cdc_rx_handshake.md
# coreaxitoahbl_cdc_rx_handshake

Receive side of the toggle-handshake clock-domain crossing in the AXI-to-AHB-Lite bridge. It consumes the already-synchronized request toggle from the 2-stage synchronizer, captures the quasi-static data bus held by the source domain, and returns an acknowledge toggle for the source's own synchronizer. Captured words go into a small FIFO drained by a valid/ready handshake toward the AHB-Lite master logic, so one source transfer can be in flight while the consumer stalls.

## Interface
- DATA_WIDTH, 32: width of the crossed data word (1..128).
- FIFO_DEPTH, 2: receive FIFO entries; power of two, 2..16.
- CNT_WIDTH, 2: width of rxCount; must be ≥ log2(FIFO_DEPTH)+1 (2 for the default depth).

- CLK  input  1  single clock for all logic.
- RESET  input  1  asynchronous, active-high reset.
- reqToggleSync  input  1  request toggle, already synchronized into CLK domain.
- asyncData  input  DATA_WIDTH  source-domain data, stable whenever reqToggleSync ≠ ackToggle.
- ackToggle  output  1  acknowledge toggle, registered, returned to source-domain synchronizer.
- rxValid  output  1  FIFO head valid.
- rxData  output  DATA_WIDTH  FIFO head word.
- rxReady  input  1  consumer accepts head when rxValid && rxReady.
- rxCount  output  CNT_WIDTH  current FIFO occupancy.
- rxStall  output  1  request pending but FIFO full.

## Operation
- pending = reqToggleSync XOR ackToggle (combinational).
- capture = pending && (rxCount < FIFO_DEPTH). On capture: asyncData is written at the write pointer, the write pointer increments modulo FIFO_DEPTH, and ackToggle inverts.
- pop = rxValid && rxReady. On pop: the read pointer increments modulo FIFO_DEPTH.
- Occupancy: next rxCount = rxCount + capture − pop. Simultaneous capture and pop leaves the count unchanged.
- Full gating uses the current count only. A pop in the same cycle does not enable a capture while full; there is no pass-through.
- rxValid = (rxCount ≠ 0). rxData = mem[rdPtr]. rxData is undefined while rxValid is 0; the bench must not check it then.
- rxStall = pending && (rxCount == FIFO_DEPTH).
- Two-state control, derived from registers:
  - IDLE (pending = 0): moves to WAIT_ACK when reqToggleSync flips.
  - WAIT_ACK (pending = 1): returns to IDLE on the capture edge.
  - No additional state encoding is required.
- Source protocol: the source toggles its request only after seeing ackToggle equal to its last request. A reqToggleSync flip while pending is therefore illegal and need not be detected.
- Reset (asynchronous, any time, including mid-transfer) forces:
  - ackToggle=0, rxCount=0, rxValid=0, rxStall=0, both pointers 0.
  - FIFO contents are not cleared.
  - The source domain is reset by the same system reset. After release, reqToggleSync=0, so pending=0.

## Timing
- Capture latency: pending observed high before edge N gives the word in the FIFO, ackToggle flipped, and rxValid=1 (if previously empty), all after edge N. That is 1 cycle from pending to rxValid.
- pending falls after edge N because ackToggle now equals reqToggleSync. No double capture.
- Round trip as seen by the source: 2 cycles (synchronizer) + 1 cycle (this block) + 2 source cycles (ack synchronizer).
- Pop: rxData/rxValid update after the edge on which pop is sampled. Throughput is 1 word/cycle out; input is limited by the toggle round trip.
- While stalled, ackToggle holds. Capture occurs on the first edge where rxCount < FIFO_DEPTH, i.e. 1 cycle after the pop that freed the slot.
- Pointer wrap: after FIFO_DEPTH captures, wrPtr returns to 0. Ordering is strictly FIFO across the wrap.

## Test plan
- Reset then single transfer: asyncData=0xA5A5_0001, flip reqToggleSync 0→1 with rxReady=1 -> ackToggle=1 and rxValid=1 with rxData=0xA5A5_0001 one cycle later; rxValid=0 the following cycle; rxCount back to 0.
- Fill and stall: rxReady=0, send 0x11, 0x22, 0x33 with a correctly modelled handshake -> rxCount=2, rxStall=1 on the third request, ackToggle unchanged. Raise rxReady for one cycle -> 0x11 popped, 0x33 captured on the next edge, ackToggle flips, rxStall=0.
- Simultaneous capture and pop: rxCount=1 holding 0x44, pending for 0x55, rxReady=1 -> rxCount stays 1 and the head becomes 0x55 next cycle.
- Pointer wrap: 7 back-to-back transfers 0x01..0x07 with random rxReady -> outputs in order 0x01..0x07, no loss or duplication, rxCount never exceeds 2.
- Reset mid-operation: rxCount=2 and pending=1, assert RESET asynchronously between edges -> ackToggle, rxValid, rxStall, and rxCount are 0 immediately, not at the next edge. After release with reqToggleSync=0, there is no capture.
- Back-to-back toggle protocol with a 2-stage synchronizer model on both directions: 100 random words -> scoreboard match, and no cycle with pending=1 immediately after a capture edge.
